// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one-at-a-time word reads
// to instruction memory and buffers returned instructions with their PCs in a FIFO.
module if_prefetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc_plus4
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

   state_t          state, state_nxt;
   logic [31:0]     fpc, fpc_nxt;
   logic [31:0]     raddr, raddr_nxt;
   logic [31:0]     buf_instr [DEPTH];
   logic [31:0]     buf_pc    [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count, count_nxt;
   logic            push, pop;
   logic [31:0]     redirect_tgt;

   assign redirect_tgt = {redirect_pc[31:2], 2'b00};
   assign push         = (state == WAIT) && imem_ack && !redirect;
   assign pop          = instr_valid && !stall && !redirect;

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + CW'(1);
      else if (!push && pop)
         count_nxt = count - CW'(1);
   end

   always_comb begin
      fpc_nxt = fpc;
      if (redirect)
         fpc_nxt = redirect_tgt;
      else if (push)
         fpc_nxt = raddr + 32'd4;
   end

   always_comb begin
      state_nxt = state;
      raddr_nxt = raddr;
      case (state)
         IDLE: begin
            if (!redirect && (count < FULL)) begin
               raddr_nxt = fpc;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            // An ack that coincides with a redirect retires the old request, so the
            // new target can be issued immediately without passing through DRAIN.
            if (imem_ack && redirect) begin
               raddr_nxt = redirect_tgt;
            end else if (imem_ack) begin
               if (count_nxt < FULL)
                  raddr_nxt = raddr + 32'd4;
               else
                  state_nxt = IDLE;
            end else if (redirect) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (imem_ack) begin
               raddr_nxt = fpc_nxt;
               state_nxt = WAIT;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         fpc    <= RESET_PC;
         raddr  <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            buf_instr[i] <= '0;
            buf_pc[i]    <= '0;
         end
      end else begin
         state <= state_nxt;
         fpc   <= fpc_nxt;
         raddr <= raddr_nxt;
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               buf_instr[wr_ptr] <= imem_rdata;
               buf_pc[wr_ptr]    <= raddr;
               wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
         end
      end
   end

   assign imem_req       = (state != IDLE);
   assign imem_addr      = raddr;
   assign instr_valid    = (count != '0);
   assign instr          = buf_instr[rd_ptr];
   assign instr_pc       = buf_pc[rd_ptr];
   assign instr_pc_plus4 = instr_pc + 32'd4;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: directed scenarios plus a randomized run scored
// against an in-order instruction-stream model.
module tb_if_prefetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;

   logic        w_rst;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_valid;
   logic [31:0] w_instr;
   logic [31:0] w_pc;
   logic [31:0] w_pc_plus4;

   int checks;
   int failures;

   int   lat_min;
   int   lat_max;
   int   wcnt;
   int   cur_lat;
   logic lat_ack;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   if_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
   );

   if_prefetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rst(w_rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(mem_word(w_addr)),
      .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc), .instr_pc_plus4(w_pc_plus4)
   );

   assign imem_ack   = imem_req & lat_ack;
   assign imem_rdata = mem_word(imem_addr);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Variable-latency memory: ack is raised in the cur_lat-th cycle of a request.
   initial begin
      wcnt    = 0;
      cur_lat = 1;
      lat_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (lat_ack) begin
            wcnt    = 0;
            cur_lat = $urandom_range(lat_max, lat_min);
         end
         if (imem_req === 1'b1) begin
            wcnt++;
            lat_ack = (wcnt >= cur_lat);
         end else begin
            wcnt    = 0;
            lat_ack = 1'b0;
            cur_lat = $urandom_range(lat_max, lat_min);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      lat_min = 1; lat_max = 1;
      rst = 1'b0;
      tick();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
      checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr); end
      checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", instr_pc); end
      checks++; if (instr_pc_plus4 !== 32'h4) begin failures++; $display("FAIL reset_pc4 got=%h exp=4", instr_pc_plus4); end
      rst = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         failures++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
      end
   endtask

   task automatic test_stream();
      logic [31:0] e;
      lat_min = 1; lat_max = 1; stall = 1'b0;
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         tick();
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k - 1))) begin
            failures++; $display("FAIL stream_addr k=%0d got req=%b addr=%h exp addr=%h", k, imem_req, imem_addr, 32'(4 * (k - 1)));
         end
         if (k == 1) begin
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_valid0 got=%b exp=0", instr_valid); end
         end else begin
            e = 32'(4 * (k - 2));
            checks++; if (instr_valid !== 1'b1 || instr_pc !== e || instr !== mem_word(e)) begin
               failures++; $display("FAIL stream_head k=%0d got v=%b pc=%h i=%h exp pc=%h i=%h", k, instr_valid, instr_pc, instr, e, mem_word(e));
            end
         end
      end
   endtask

   task automatic test_stall_full();
      lat_min = 1; lat_max = 1; stall = 1'b1;
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k - 1))) begin
            failures++; $display("FAIL full_fill k=%0d got req=%b addr=%h", k, imem_req, imem_addr);
         end
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin
            failures++; $display("FAIL full_hold got req=%b v=%b pc=%h exp req=0 v=1 pc=0", imem_req, instr_valid, instr_pc);
         end
      end
      stall = 1'b0;
      tick();
      checks++; if (imem_req !== 1'b0 || instr_pc !== 32'h4 || instr !== mem_word(32'h4)) begin
         failures++; $display("FAIL full_pop1 got req=%b pc=%h exp req=0 pc=4", imem_req, instr_pc);
      end
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_pc !== 32'h8) begin
         failures++; $display("FAIL full_resume got req=%b addr=%h pc=%h exp req=1 addr=10 pc=8", imem_req, imem_addr, instr_pc);
      end
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC || instr !== mem_word(32'hC)) begin
         failures++; $display("FAIL full_pop3 got v=%b pc=%h exp pc=c", instr_valid, instr_pc);
      end
   endtask

   task automatic test_latency_redirect();
      int n;
      lat_min = 3; lat_max = 3; stall = 1'b0;
      do_reset();
      n = 0;
      while (!(imem_req === 1'b1 && imem_addr === 32'h8) && n < 40) begin tick(); n++; end
      checks++; if (n >= 40) begin failures++; $display("FAIL lat_reach8 got addr=%h exp addr=8 within 40 cycles", imem_addr); end
      tick();
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL lat_flush got v=%b exp=0", instr_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
         failures++; $display("FAIL lat_drain got req=%b addr=%h exp req=1 addr=8", imem_req, imem_addr);
      end
      n = 0;
      while (imem_req === 1'b1 && imem_addr === 32'h8 && n < 10) begin tick(); n++; end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         failures++; $display("FAIL lat_newreq got req=%b addr=%h exp req=1 addr=100", imem_req, imem_addr);
      end
      n = 0;
      while (instr_valid !== 1'b1 && n < 10) begin tick(); n++; end
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin
         failures++; $display("FAIL lat_first got v=%b pc=%h i=%h exp pc=100 i=%h", instr_valid, instr_pc, instr, mem_word(32'h100));
      end
   endtask

   task automatic test_redirect_ack(input logic [31:0] target, input logic [31:0] aligned);
      lat_min = 1; lat_max = 1; stall = 1'b0;
      do_reset();
      repeat (4) tick();
      redirect = 1'b1; redirect_pc = target;
      tick();
      redirect = 1'b0;
      checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== aligned) begin
         failures++; $display("FAIL redir_ack got v=%b req=%b addr=%h exp v=0 req=1 addr=%h", instr_valid, imem_req, imem_addr, aligned);
      end
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== aligned || instr !== mem_word(aligned)) begin
         failures++; $display("FAIL redir_head got v=%b pc=%h exp pc=%h", instr_valid, instr_pc, aligned);
      end
   endtask

   task automatic test_wrap();
      w_rst = 1'b0;
      tick();
      checks++; if (w_req !== 1'b0 || w_addr !== 32'hFFFF_FFF8) begin
         failures++; $display("FAIL wrap_reset got req=%b addr=%h exp req=0 addr=fffffff8", w_req, w_addr);
      end
      w_rst = 1'b1;
      tick();
      checks++; if (w_addr !== 32'hFFFF_FFF8 || w_req !== 1'b1) begin failures++; $display("FAIL wrap_a0 got addr=%h exp fffffff8", w_addr); end
      tick();
      checks++; if (w_addr !== 32'hFFFF_FFFC || w_pc !== 32'hFFFF_FFF8) begin
         failures++; $display("FAIL wrap_a1 got addr=%h pc=%h exp addr=fffffffc pc=fffffff8", w_addr, w_pc);
      end
      tick();
      checks++; if (w_addr !== 32'h0 || w_pc !== 32'hFFFF_FFFC || w_pc_plus4 !== 32'h0 || w_instr !== mem_word(32'hFFFF_FFFC)) begin
         failures++; $display("FAIL wrap_a2 got addr=%h pc=%h pc4=%h exp addr=0 pc=fffffffc pc4=0", w_addr, w_pc, w_pc_plus4);
      end
   endtask

   task automatic test_reset_mid();
      lat_min = 3; lat_max = 3; stall = 1'b0;
      do_reset();
      tick();
      tick();
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL midrst_pre got req=%b exp=1", imem_req); end
      rst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
         failures++; $display("FAIL midrst_clear got req=%b v=%b addr=%h exp 0 0 0", imem_req, instr_valid, imem_addr);
      end
      tick();
      rst = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         failures++; $display("FAIL midrst_restart got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      logic        prev_redir;
      int          npops;
      lat_min = 1; lat_max = 4; stall = 1'b0; redirect = 1'b0;
      do_reset();
      exp_pc = 32'h0; prev_redir = 1'b0; npops = 0;
      for (int c = 0; c < 800; c++) begin
         stall       = ($urandom_range(9, 0) < 3);
         redirect    = ($urandom_range(24, 0) == 0);
         redirect_pc = $urandom;
         if (prev_redir) begin
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rnd_flush c=%0d got v=%b exp=0", c, instr_valid); end
         end
         if (redirect) begin
            exp_pc = {redirect_pc[31:2], 2'b00};
         end else if (instr_valid === 1'b1 && !stall) begin
            checks++;
            if (instr_pc !== exp_pc || instr !== mem_word(exp_pc) || instr_pc_plus4 !== exp_pc + 32'd4) begin
               failures++; $display("FAIL rnd_pop c=%0d got pc=%h i=%h pc4=%h exp pc=%h i=%h", c, instr_pc, instr, instr_pc_plus4, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            npops++;
         end
         prev_redir = redirect;
         tick();
      end
      redirect = 1'b0; stall = 1'b0;
      checks++; if (npops < 60) begin failures++; $display("FAIL rnd_progress got pops=%0d exp >=60", npops); end
   endtask

   initial begin
      checks = 0; failures = 0;
      lat_min = 1; lat_max = 1;
      rst = 1'b0; w_rst = 1'b0;
      stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      test_reset();
      test_stream();
      test_stall_full();
      test_latency_redirect();
      test_redirect_ack(32'h0000_0040, 32'h0000_0040);
      test_redirect_ack(32'h0000_0203, 32'h0000_0200);
      test_wrap();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_prefetch_unit.md
# if_prefetch_unit

Instruction-fetch front end for the pipelined RISC-V core. It owns the fetch PC, issues word reads to instruction memory over a req/ack handshake that tolerates variable latency, and buffers returned instructions with their PCs in a small FIFO. The FIFO feeds the IF/ID register of the core's datapath. Branch/jump redirects from the execute stage flush the buffer, and wrong-path responses still in flight are dropped.

## Interface
- DEPTH, 4: prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: fetch address after reset.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  from the hazard unit; decode does not accept the head entry this cycle.
- redirect  in  1  branch or jump taken in EX; single-cycle pulse.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word address of the request; held stable while imem_req is high.
- imem_ack  in  1  read data valid; completes the current request in this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack is high.
- instr_valid  out  1  FIFO not empty.
- instr  out  32  instruction at the FIFO head.
- instr_pc  out  32  PC of the head instruction.
- instr_pc_plus4  out  32  instr_pc + 4, modulo 2^32.

## Operation
- State: fetch PC `fpc`, request address `raddr`, FIFO storage, read/write pointers, occupancy `count` (0..DEPTH), and a 3-state FSM: IDLE, WAIT, DRAIN.
- imem_req = (state is WAIT or DRAIN). imem_addr = raddr.
- Only one request is outstanding at a time. A request is never withdrawn before imem_ack, except by reset.
- **Pop:** occurs when instr_valid && !stall && !redirect. The read pointer advances by 1.
- **Push:** occurs on imem_ack in WAIT with no redirect in the same cycle. The entry {imem_rdata, raddr} is written at the write pointer. fpc is set to raddr+4.
- **count:** +1 on push only, −1 on pop only, unchanged when push and pop occur together.
- **Redirect** (any state) has the highest priority:
  - FIFO flushed: pointers and count go to 0.
  - fpc := {redirect_pc[31:2], 2'b00}.
  - Any push in the same cycle is suppressed.
- **IDLE:**
  - If redirect, stay IDLE.
  - Otherwise, if count < DEPTH: raddr := fpc, go to WAIT.
  - Otherwise stay IDLE.
- **WAIT:**
  - ack && redirect: response discarded. raddr := new fpc, stay WAIT.
  - ack, no redirect: push. If count after this cycle < DEPTH, raddr := raddr+4 and stay WAIT (back-to-back requests). Otherwise go to IDLE.
  - redirect without ack: go to DRAIN; raddr is unchanged.
  - Neither: hold.
- **DRAIN:** the outstanding wrong-path request is completing.
  - On ack: discard the data, raddr := fpc, go to WAIT.
  - A redirect in DRAIN only updates fpc (and flushes the FIFO).
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 0.

## Timing
- **Reset values:**
  - state IDLE, fpc = raddr = RESET_PC, count 0, FIFO storage 0.
  - Outputs: imem_req 0, imem_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0, instr_pc_plus4 4.
- **First request:** imem_req rises in the first clock edge after rst deasserts.
- **Latency:** an instruction acked at edge N is visible on instr/instr_valid after edge N.
- **Throughput:** with a zero-wait memory (ack in the same cycle as req) and no stall, one instruction per cycle is sustained.
- **Full FIFO:** no request is issued while count == DEPTH. After a pop, imem_req rises one cycle later (IDLE→WAIT).
- **Redirect:** instr_valid is 0 in the cycle after redirect. The first new-path request is issued the cycle after redirect from IDLE, immediately in WAIT, or after the drained ack in DRAIN.
- **Reset mid-transfer:** all state clears asynchronously and imem_req drops. The memory must tolerate an abandoned request.

## Test plan
- **Reset, zero-wait memory, stall=0:** imem_addr sequence 0, 4, 8, … with imem_req continuously high. instr_valid high from cycle 2. instr_pc increments by 4 each cycle.
- **Stall held with DEPTH=4:** exactly 4 pushes, then imem_req goes to 0 and count is 4. Release stall: entries pop in order 0, 4, 8, 12. imem_req rises one cycle after the first pop, with address 16.
- **Memory with 3-cycle ack latency, then redirect to 32'h100 in the second wait cycle:**
  - The request at address 8 stays high until its ack (DRAIN).
  - Its data is never output.
  - The next request is to 32'h100.
  - The first valid instruction afterwards has instr_pc 32'h100.
- **Redirect in the same cycle as an ack in WAIT, plus a pop-eligible head:** no push, FIFO empty next cycle, next imem_addr = redirect target.
- **redirect_pc = 32'h0000_0203:** fetch goes to 32'h200.
- **RESET_PC = 32'hFFFF_FFF8:** addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. instr_pc_plus4 of the FFFF_FFFC entry is 0.
- **rst pulsed low while imem_req is high in WAIT:** imem_req drops immediately, instr_valid is 0, and the next request after release is to RESET_PC.
